// File: rtl/gcn_row_write_scheduler.sv
// gcn_row_write_scheduler
//
// Steps through the result rows of one GCN layer pass (adjacency x feature x weight).
// For each row it issues a compute request to the ADJ.FM.WM datapath and waits for
// completion. It then holds the write strobe until the output memory accepts the row.
//
// Optional feature: define GCN_SCHED_TIMEOUT_EN to enable a compute watchdog. When a
// row's compute takes TIMEOUT_CYCLES cycles without dp_done, the pass aborts: no write
// is issued for that row, error is set (sticky), and done pulses once.
//
// Ports:
//   clk                    in   single clock, rising edge
//   reset                  in   asynchronous reset, active low
//   start                  in   start one layer pass (sampled only in IDLE)
//   dp_done                in   datapath finished the current row (sampled only in COMPUTE)
//   mem_ready              in   write accepted this cycle (sampled only in WRITE)
//   compute_start          out  one-cycle pulse to the datapath
//   adj_read_en            out  adjacency row read strobe, coincident with compute_start
//   row_addr               out  current row index for both read and write paths
//   is_write_result_to_mem out  write strobe, held high while in WRITE
//   busy                   out  high in every state except IDLE
//   done                   out  one-cycle completion pulse
//   error                  out  sticky watchdog abort flag (tied low without the watchdog)
//   row_cols               out  constant DOT_PROD_COLS
module gcn_row_write_scheduler #(
    parameter int unsigned NUM_NODES      = 6,
    parameter int unsigned DOT_PROD_COLS  = 3,
    parameter int unsigned TIMEOUT_CYCLES = 64,
    localparam int unsigned ROW_W = (NUM_NODES > 1) ? $clog2(NUM_NODES) : 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             dp_done,
    input  logic             mem_ready,
    output logic             compute_start,
    output logic             adj_read_en,
    output logic [ROW_W-1:0] row_addr,
    output logic             is_write_result_to_mem,
    output logic             busy,
    output logic             done,
    output logic             error,
    output logic [7:0]       row_cols
);

    localparam logic [ROW_W-1:0] LAST_ROW = ROW_W'(NUM_NODES - 1);

    typedef enum logic [2:0] {
        StIdle,
        StIssue,
        StCompute,
        StWrite,
        StDone
`ifdef GCN_SCHED_TIMEOUT_EN
        , StAbort
`endif
    } state_e;

    state_e state;

    assign row_cols = 8'(DOT_PROD_COLS);

`ifdef GCN_SCHED_TIMEOUT_EN
    localparam int unsigned CNT_W =
        ($clog2(TIMEOUT_CYCLES + 1) > 8) ? $clog2(TIMEOUT_CYCLES + 1) : 8;
    // Count value present during the last permitted COMPUTE cycle.
    localparam logic [CNT_W-1:0] WD_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    logic [CNT_W-1:0] wd_cnt;
`else
    assign error = 1'b0;
`endif

    // All outputs are registered: each transition also loads the outputs of the
    // state being entered, so they are valid for the whole cycle spent in it.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state                  <= StIdle;
            row_addr               <= '0;
            compute_start          <= 1'b0;
            adj_read_en            <= 1'b0;
            is_write_result_to_mem <= 1'b0;
            busy                   <= 1'b0;
            done                   <= 1'b0;
`ifdef GCN_SCHED_TIMEOUT_EN
            error                  <= 1'b0;
            wd_cnt                 <= '0;
`endif
        end else begin
            compute_start <= 1'b0;
            adj_read_en   <= 1'b0;
            done          <= 1'b0;
            case (state)
                StIdle: begin
                    if (start) begin
                        state         <= StIssue;
                        row_addr      <= '0;
                        compute_start <= 1'b1;
                        adj_read_en   <= 1'b1;
                        busy          <= 1'b1;
`ifdef GCN_SCHED_TIMEOUT_EN
                        error         <= 1'b0;
`endif
                    end
                end
                StIssue: begin
                    state <= StCompute;
`ifdef GCN_SCHED_TIMEOUT_EN
                    wd_cnt <= '0;
`endif
                end
                StCompute: begin
                    // dp_done wins over a watchdog expiry in the same cycle.
                    if (dp_done) begin
                        state                  <= StWrite;
                        is_write_result_to_mem <= 1'b1;
                    end
`ifdef GCN_SCHED_TIMEOUT_EN
                    else if (wd_cnt == WD_LAST) begin
                        state <= StAbort;
                        error <= 1'b1;
                        done  <= 1'b1;
                    end else begin
                        wd_cnt <= wd_cnt + 1'b1;
                    end
`endif
                end
                StWrite: begin
                    if (mem_ready) begin
                        is_write_result_to_mem <= 1'b0;
                        // Terminal compare precedes the increment, so row_addr never wraps.
                        if (row_addr == LAST_ROW) begin
                            state <= StDone;
                            done  <= 1'b1;
                        end else begin
                            state         <= StIssue;
                            row_addr      <= row_addr + 1'b1;
                            compute_start <= 1'b1;
                            adj_read_en   <= 1'b1;
                        end
                    end
                end
                StDone: begin
                    state <= StIdle;
                    busy  <= 1'b0;
                end
`ifdef GCN_SCHED_TIMEOUT_EN
                StAbort: begin
                    state <= StIdle;
                    busy  <= 1'b0;
                end
`endif
                default: begin
                    state                  <= StIdle;
                    busy                   <= 1'b0;
                    is_write_result_to_mem <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_gcn_row_write_scheduler.sv
module tb_gcn_row_write_scheduler;

    localparam int unsigned N    = 6;
    localparam int unsigned COLS = 3;
    localparam int unsigned TMO  = 8;
    localparam int          RW   = 3;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic          start = 1'b0;
    logic          dp_done = 1'b0;
    logic          mem_ready = 1'b0;
    logic          compute_start;
    logic          adj_read_en;
    logic [RW-1:0] row_addr;
    logic          is_write_result_to_mem;
    logic          busy;
    logic          done;
    logic          error;
    logic [7:0]    row_cols;

    gcn_row_write_scheduler #(
        .NUM_NODES      (N),
        .DOT_PROD_COLS  (COLS),
        .TIMEOUT_CYCLES (TMO)
    ) dut (
        .clk                    (clk),
        .reset                  (reset),
        .start                  (start),
        .dp_done                (dp_done),
        .mem_ready              (mem_ready),
        .compute_start          (compute_start),
        .adj_read_en            (adj_read_en),
        .row_addr               (row_addr),
        .is_write_result_to_mem (is_write_result_to_mem),
        .busy                   (busy),
        .done                   (done),
        .error                  (error),
        .row_cols               (row_cols)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // Per-pass observations, written only by the stimulus process.
    int wq[$];
    int n_done, wr2_cycles, n_overlap;
    int c0_cs, c0_adj, c0_row, c0_busy, c0_err;
    int err_at_done, busy_after, err_after;
    int dc;

    task automatic check_eq(input string tag, input int got, input int exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_rows(input string tag);
        check_eq({tag, "_nwrites"}, wq.size(), N);
        for (int i = 0; i < wq.size() && i < N; i++)
            check_eq($sformatf("%s_row%0d", tag, i), wq[i], i);
    endtask

    // One layer pass. Inputs are driven each cycle from the observed phase:
    //   dp_delay  COMPUTE cycles with dp_done low before it rises
    //   dp_spur   dp_done held high outside COMPUTE
    //   stall_*   mem_ready held low stall_len cycles on the write of row stall_row
    //   restart   start re-asserted during COMPUTE of row 1
    //   rst_row3  assert reset in the middle of the row 3 write and stop
    task automatic run_pass(input int dp_delay, input bit dp_spur, input int stall_row,
                            input int stall_len, input bit restart, input bit rst_row3,
                            output int done_cyc);
        int  comp_cnt;
        int  stall_cnt;
        bit  in_compute;
        comp_cnt   = 0;
        stall_cnt  = 0;
        done_cyc   = -1;
        wq.delete();
        n_done     = 0;
        wr2_cycles = 0;
        n_overlap  = 0;
        busy_after = -1;
        err_after  = -1;
        start   = 1'b1;
        dp_done = dp_spur;
        tick();
        start = 1'b0;
        for (int c = 0; c < 400; c++) begin
            in_compute = busy && !compute_start && !is_write_result_to_mem && !done;
            if (c == 0) begin
                c0_cs   = compute_start;
                c0_adj  = adj_read_en;
                c0_row  = row_addr;
                c0_busy = busy;
                c0_err  = error;
            end
            if (in_compute) begin
                dp_done = (comp_cnt >= dp_delay);
                comp_cnt++;
            end else begin
                dp_done  = dp_spur;
                comp_cnt = 0;
            end
            if (is_write_result_to_mem && int'(row_addr) == stall_row && stall_cnt < stall_len) begin
                mem_ready = 1'b0;
                stall_cnt++;
            end else begin
                mem_ready = 1'b1;
            end
            start = restart && in_compute && row_addr == 1;
            if (is_write_result_to_mem && mem_ready) wq.push_back(int'(row_addr));
            if (is_write_result_to_mem && row_addr == 2) wr2_cycles++;
            if (is_write_result_to_mem && compute_start) n_overlap++;
            if (done) begin
                n_done++;
                if (done_cyc < 0) begin
                    done_cyc    = c;
                    err_at_done = error;
                end
            end
            if (done_cyc >= 0 && c == done_cyc + 1) begin
                busy_after = busy;
                err_after  = error;
            end
            if (rst_row3 && is_write_result_to_mem && row_addr == 3) begin
                #2;
                reset = 1'b0;
                #1;
                check_eq("rst_mid_write", is_write_result_to_mem, 0);
                check_eq("rst_mid_cstart", compute_start, 0);
                check_eq("rst_mid_busy", busy, 0);
                check_eq("rst_mid_done", done, 0);
                check_eq("rst_mid_row", row_addr, 0);
                tick();
                reset = 1'b1;
                start = 1'b0;
                dp_done = 1'b0;
                tick();
                return;
            end
            if (done_cyc >= 0 && c == done_cyc + 3) break;
            tick();
        end
        start   = 1'b0;
        dp_done = 1'b0;
        if (done_cyc < 0) check_eq("done_seen", 0, 1);
    endtask

    initial begin
        // Reset values
        reset = 1'b0;
        tick();
        tick();
        check_eq("rst_cstart", compute_start, 0);
        check_eq("rst_adj", adj_read_en, 0);
        check_eq("rst_write", is_write_result_to_mem, 0);
        check_eq("rst_busy", busy, 0);
        check_eq("rst_done", done, 0);
        check_eq("rst_error", error, 0);
        check_eq("rst_row", row_addr, 0);
        check_eq("row_cols", row_cols, COLS);
        reset = 1'b1;
        tick();

        // Spurious dp_done in IDLE
        dp_done = 1'b1;
        tick();
        tick();
        tick();
        check_eq("idle_spur_busy", busy, 0);
        check_eq("idle_spur_cstart", compute_start, 0);
        dp_done = 1'b0;

        // Best case: 3 cycles per row
        run_pass(0, 1'b0, -1, 0, 1'b0, 1'b0, dc);
        check_eq("a_c0_cstart", c0_cs, 1);
        check_eq("a_c0_adj", c0_adj, 1);
        check_eq("a_c0_row", c0_row, 0);
        check_eq("a_c0_busy", c0_busy, 1);
        check_eq("a_done_cycle", dc, 18);
        check_eq("a_busy_after", busy_after, 0);
        check_eq("a_ndone", n_done, 1);
        check_eq("a_overlap", n_overlap, 0);
        check_eq("a_error", err_after, 0);
        check_eq("a_last_row", row_addr, N - 1);
        check_rows("a");

        // mem_ready low 4 cycles on row 2
        run_pass(0, 1'b0, 2, 4, 1'b0, 1'b0, dc);
        check_eq("b_done_cycle", dc, 22);
        check_eq("b_wr2_cycles", wr2_cycles, 5);
        check_eq("b_ndone", n_done, 1);
        check_rows("b");

        // start re-asserted during COMPUTE of row 1
        run_pass(1, 1'b0, -1, 0, 1'b1, 1'b0, dc);
        check_eq("c_done_cycle", dc, 24);
        check_eq("c_ndone", n_done, 1);
        check_rows("c");

        // Spurious dp_done in ISSUE/WRITE, 2-cycle compute delay, 2-cycle stall on row 4
        run_pass(2, 1'b1, 4, 2, 1'b0, 1'b0, dc);
        check_eq("d_done_cycle", dc, 32);
        check_eq("d_ndone", n_done, 1);
        check_eq("d_overlap", n_overlap, 0);
        check_rows("d");

        // Reset during the row 3 write, then a fresh pass from row 0
        run_pass(0, 1'b0, 3, 50, 1'b0, 1'b1, dc);
        check_eq("e_busy_idle", busy, 0);
        run_pass(0, 1'b0, -1, 0, 1'b0, 1'b0, dc);
        check_eq("e_c0_row", c0_row, 0);
        check_eq("e_done_cycle", dc, 18);
        check_rows("e");

`ifdef GCN_SCHED_TIMEOUT_EN
        // Watchdog: dp_done never rises on row 0
        run_pass(1000, 1'b0, -1, 0, 1'b0, 1'b0, dc);
        check_eq("f_done_cycle", dc, 1 + TMO);
        check_eq("f_err_at_done", err_at_done, 1);
        check_eq("f_nwrites", wq.size(), 0);
        check_eq("f_ndone", n_done, 1);
        check_eq("f_err_sticky", err_after, 1);
        check_eq("f_busy_after", busy_after, 0);
        // Next accepted start clears error
        run_pass(0, 1'b0, -1, 0, 1'b0, 1'b0, dc);
        check_eq("f_err_cleared", c0_err, 0);
        check_eq("f_done_cycle2", dc, 18);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
